// File: rtl/perf_bus_arbiter.sv
// Two-master round-robin arbiter for the 64-bit peripheral bus with fixed slave read latency.
// Define PERF_BUS_ARB_FIXED_PRIO_EN to give master 0 strict priority on simultaneous requests.
module perf_bus_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_wren,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_wren,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_dout,
  output logic                  s_wren,
  input  logic [DATA_WIDTH-1:0] s_din
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t     state;
  logic       cur;
  logic [3:0] cnt;
  logic       win;

`ifndef PERF_BUS_ARB_FIXED_PRIO_EN
  logic last;
`endif

  // NOTE: win gets a default before any branch so no latch is inferred.
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) begin
`ifdef PERF_BUS_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last;
`endif
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= 1'b0;
      cnt       <= '0;
`ifndef PERF_BUS_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      s_addr    <= '0;
      s_dout    <= '0;
      s_wren    <= 1'b0;
    end else begin
      // Pulsed outputs fall back to 0 unless a state below raises them.
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      s_wren    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            cur    <= win;
`ifndef PERF_BUS_ARB_FIXED_PRIO_EN
            last   <= win;
`endif
            s_addr <= win ? m1_addr  : m0_addr;
            s_dout <= win ? m1_wdata : m0_wdata;
            s_wren <= win ? m1_wren  : m0_wren;
            m0_gnt <= ~win;
            m1_gnt <= win;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // s_wren still holds the issued transaction type during this cycle.
          if (s_wren) begin
            state <= S_IDLE;
          end else begin
            cnt   <= 4'(RD_LAT - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (cur) begin
              m1_rdata  <= s_din;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= s_din;
              m0_rvalid <= 1'b1;
            end
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_bus_arbiter.sv
// Directed bench for perf_bus_arbiter; three instances with RD_LAT = 1, 4 and 3.
// Build with PERF_BUS_ARB_FIXED_PRIO_EN defined to check the fixed-priority grant order.
module tb_perf_bus_arbiter;

  logic        clk;
  logic        rst       [3];
  logic        m0_req    [3];
  logic        m1_req    [3];
  logic        m0_wren   [3];
  logic        m1_wren   [3];
  logic [63:0] m0_addr   [3];
  logic [63:0] m1_addr   [3];
  logic [63:0] m0_wdata  [3];
  logic [63:0] m1_wdata  [3];
  logic [63:0] s_din     [3];
  logic        m0_gnt    [3];
  logic        m1_gnt    [3];
  logic        m0_rvalid [3];
  logic        m1_rvalid [3];
  logic        s_wren    [3];
  logic [63:0] m0_rdata  [3];
  logic [63:0] m1_rdata  [3];
  logic [63:0] s_addr    [3];
  logic [63:0] s_dout    [3];

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    perf_bus_arbiter #(
      .DATA_WIDTH(64),
      .ADDR_WIDTH(64),
      .RD_LAT    ((g == 0) ? 1 : (g == 1) ? 4 : 3)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .m0_req   (m0_req[g]),
      .m0_addr  (m0_addr[g]),
      .m0_wdata (m0_wdata[g]),
      .m0_wren  (m0_wren[g]),
      .m0_gnt   (m0_gnt[g]),
      .m0_rdata (m0_rdata[g]),
      .m0_rvalid(m0_rvalid[g]),
      .m1_req   (m1_req[g]),
      .m1_addr  (m1_addr[g]),
      .m1_wdata (m1_wdata[g]),
      .m1_wren  (m1_wren[g]),
      .m1_gnt   (m1_gnt[g]),
      .m1_rdata (m1_rdata[g]),
      .m1_rvalid(m1_rvalid[g]),
      .s_addr   (s_addr[g]),
      .s_dout   (s_dout[g]),
      .s_wren   (s_wren[g]),
      .s_din    (s_din[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; registered outputs are settled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    check({tag, "_m0_gnt"},    64'(m0_gnt[i]),    64'd0);
    check({tag, "_m1_gnt"},    64'(m1_gnt[i]),    64'd0);
    check({tag, "_m0_rvalid"}, 64'(m0_rvalid[i]), 64'd0);
    check({tag, "_m1_rvalid"}, 64'(m1_rvalid[i]), 64'd0);
    check({tag, "_s_wren"},    64'(s_wren[i]),    64'd0);
    check({tag, "_s_addr"},    s_addr[i],         64'd0);
    check({tag, "_s_dout"},    s_dout[i],         64'd0);
    check({tag, "_m0_rdata"},  m0_rdata[i],       64'd0);
    check({tag, "_m1_rdata"},  m1_rdata[i],       64'd0);
  endtask

  int          seq_m [8];
  int          seq_c [8];
  int          exp_m [8];
  int          n_gnt;
  int          cnt0;
  int          cnt1;
  logic        seen;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]      = 1'b1;
      m0_req[i]   = 1'b0;
      m1_req[i]   = 1'b0;
      m0_wren[i]  = 1'b0;
      m1_wren[i]  = 1'b0;
      m0_addr[i]  = '0;
      m1_addr[i]  = '0;
      m0_wdata[i] = '0;
      m1_wdata[i] = '0;
      s_din[i]    = JUNK;
    end
    #12;
    for (int i = 0; i < 3; i++) check_idle_outputs(i, $sformatf("reset%0d", i));
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    tick();

    // Single write from m0.
    m0_req[0] = 1'b1; m0_addr[0] = 64'h10; m0_wdata[0] = 64'hDEAD_BEEF; m0_wren[0] = 1'b1;
    tick();
    check("wr_m0_gnt",  64'(m0_gnt[0]), 64'd1);
    check("wr_m1_gnt",  64'(m1_gnt[0]), 64'd0);
    check("wr_s_wren",  64'(s_wren[0]), 64'd1);
    check("wr_s_addr",  s_addr[0],      64'h10);
    check("wr_s_dout",  s_dout[0],      64'hDEAD_BEEF);
    m0_req[0] = 1'b0; m0_wren[0] = 1'b0;
    tick();
    check("wr_gnt_end",    64'(m0_gnt[0]),    64'd0);
    check("wr_wren_end",   64'(s_wren[0]),    64'd0);
    check("wr_addr_held",  s_addr[0],         64'h10);
    check("wr_dout_held",  s_dout[0],         64'hDEAD_BEEF);
    check("wr_no_rvalid0", 64'(m0_rvalid[0]), 64'd0);
    tick();
    check("wr_no_rvalid1", 64'(m0_rvalid[0] | m1_rvalid[0]), 64'd0);

    // Single read from m1 with RD_LAT = 1; slave data valid only in cycle 2.
    m1_req[0] = 1'b1; m1_addr[0] = 64'h20; m1_wren[0] = 1'b0;
    tick();
    check("rd_m1_gnt", 64'(m1_gnt[0]), 64'd1);
    check("rd_m0_gnt", 64'(m0_gnt[0]), 64'd0);
    check("rd_s_wren", 64'(s_wren[0]), 64'd0);
    check("rd_s_addr", s_addr[0],      64'h20);
    m1_req[0] = 1'b0;
    tick();
    s_din[0] = 64'h1234;
    check("rd_early_rvalid", 64'(m1_rvalid[0] | m0_rvalid[0]), 64'd0);
    tick();
    s_din[0] = JUNK;
    check("rd_m1_rvalid", 64'(m1_rvalid[0]), 64'd1);
    check("rd_m1_rdata",  m1_rdata[0],       64'h1234);
    check("rd_m0_rvalid", 64'(m0_rvalid[0]), 64'd0);
    tick();
    check("rd_rvalid_pulse", 64'(m1_rvalid[0]), 64'd0);
    check("rd_rdata_held",   m1_rdata[0],       64'h1234);
    check("rd_m0_untouched", 64'(m0_rvalid[0]), 64'd0);

    // Both masters request four writes each.
`ifdef PERF_BUS_ARB_FIXED_PRIO_EN
    exp_m = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_m = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    m0_req[0] = 1'b1; m0_addr[0] = 64'h100; m0_wdata[0] = 64'hA0; m0_wren[0] = 1'b1;
    m1_req[0] = 1'b1; m1_addr[0] = 64'h200; m1_wdata[0] = 64'hB0; m1_wren[0] = 1'b1;
    n_gnt = 0; cnt0 = 0; cnt1 = 0;
    for (int cyc = 1; cyc <= 30 && n_gnt < 8; cyc++) begin
      tick();
      check("arb_onehot", 64'(m0_gnt[0] & m1_gnt[0]), 64'd0);
      if (m0_gnt[0]) begin
        check("arb_m0_addr", s_addr[0], 64'h100);
        if (n_gnt < 8) begin seq_m[n_gnt] = 0; seq_c[n_gnt] = cyc; end
        n_gnt++; cnt0++;
        if (cnt0 == 4) m0_req[0] = 1'b0;
      end
      if (m1_gnt[0]) begin
        check("arb_m1_addr", s_addr[0], 64'h200);
        if (n_gnt < 8) begin seq_m[n_gnt] = 1; seq_c[n_gnt] = cyc; end
        n_gnt++; cnt1++;
        if (cnt1 == 4) m1_req[0] = 1'b0;
      end
    end
    m0_req[0] = 1'b0; m1_req[0] = 1'b0; m0_wren[0] = 1'b0; m1_wren[0] = 1'b0;
    check("arb_count", 64'(n_gnt), 64'd8);
    for (int k = 0; k < 8 && k < n_gnt; k++) begin
      check($sformatf("arb_order%0d", k), 64'(seq_m[k]), 64'(exp_m[k]));
      check($sformatf("arb_cycle%0d", k), 64'(seq_c[k]), 64'(2 * k + 1));
    end
    tick();
    tick();

    // Reset in the middle of a RD_LAT = 4 read.
    m0_req[1] = 1'b1; m0_addr[1] = 64'h40; m0_wren[1] = 1'b0;
    tick();
    check("rst_rd_gnt",  64'(m0_gnt[1]), 64'd1);
    check("rst_rd_addr", s_addr[1],      64'h40);
    m0_req[1] = 1'b0;
    tick();
    tick();
    check("rst_rd_wait", 64'(m0_rvalid[1]), 64'd0);
    #2 rst[1] = 1'b1;
    #1;
    check_idle_outputs(1, "rst_mid");
    s_din[1] = 64'h5555;
    tick();
    tick();
    #2 rst[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | m0_rvalid[1] | m1_rvalid[1];
    end
    check("rst_no_rvalid", 64'(seen), 64'd0);
    s_din[1] = JUNK;
    m0_req[1] = 1'b1; m0_addr[1] = 64'h48;
    tick();
    check("post_rst_gnt",  64'(m0_gnt[1]), 64'd1);
    check("post_rst_addr", s_addr[1],      64'h48);
    m0_req[1] = 1'b0;
    seen = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      seen = seen | m0_rvalid[1];
    end
    s_din[1] = 64'hA5A5;
    check("post_rst_early", 64'(seen), 64'd0);
    tick();
    s_din[1] = JUNK;
    check("post_rst_rvalid", 64'(m0_rvalid[1]), 64'd1);
    check("post_rst_rdata",  m0_rdata[1],       64'hA5A5);

    // Back-to-back reads from m0 with RD_LAT = 3.
    m0_req[2] = 1'b1; m0_addr[2] = 64'h80; m0_wren[2] = 1'b0;
    tick();
    check("b2b_gnt1",  64'(m0_gnt[2]), 64'd1);
    check("b2b_addr1", s_addr[2],      64'h80);
    m0_addr[2] = 64'h88;
    tick();
    tick();
    tick();
    s_din[2] = 64'h1111;
    check("b2b_wait_gnt", 64'(m0_gnt[2] | m0_rvalid[2]), 64'd0);
    tick();
    s_din[2] = JUNK;
    check("b2b_rvalid1", 64'(m0_rvalid[2]), 64'd1);
    check("b2b_rdata1",  m0_rdata[2],       64'h1111);
    check("b2b_no_gnt",  64'(m0_gnt[2]),    64'd0);
    tick();
    check("b2b_gnt2",    64'(m0_gnt[2]),    64'd1);
    check("b2b_addr2",   s_addr[2],         64'h88);
    check("b2b_rv_low",  64'(m0_rvalid[2]), 64'd0);
    m0_req[2] = 1'b0;
    tick();
    tick();
    tick();
    s_din[2] = 64'h2222;
    check("b2b_early2", 64'(m0_rvalid[2]), 64'd0);
    tick();
    s_din[2] = JUNK;
    check("b2b_rvalid2", 64'(m0_rvalid[2]), 64'd1);
    check("b2b_rdata2",  m0_rdata[2],       64'h2222);
    check("b2b_m1_rv",   64'(m1_rvalid[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
